// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter: op encodings, amount width
// and the out-of-range amount flags carried down the pipe.
package shift_pkg;

   localparam int unsigned SH_AMTW = 8;

   typedef enum logic [2:0] {
      LSL = 3'd0,
      LSR = 3'd1,
      ASR = 3'd2,
      ROR = 3'd3,
      RRX = 3'd4
   } shift_op_t;

   typedef struct packed {
      logic oor;  // amount >= WIDTH
      logic eq;   // amount == WIDTH
      logic nz;   // amount != 0
   } amt_flags_t;

   function automatic amt_flags_t decode_amt(input logic [SH_AMTW-1:0] amt,
                                             input int unsigned width);
      amt_flags_t f;
      f.oor = (32'(amt) >= width);
      f.eq  = (32'(amt) == width);
      f.nz  = (amt != '0);
      return f;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slice: shift levels [LO,HI) on the incoming operand, then a
// registered slice. The last slice also resolves out-of-range amounts and RRX.
module shift_stage
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned TAGW     = 4,
   parameter int unsigned LO       = 0,
   parameter int unsigned HI       = 1,
   parameter bit          IS_FIRST = 1'b0,
   parameter bit          IS_LAST  = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               advance,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SH_AMTW-1:0] in_amt,
   input  logic               in_carry,
   input  shift_op_t          in_op,
   input  logic [TAGW-1:0]    in_tag,
   input  amt_flags_t         in_flags,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SH_AMTW-1:0] out_amt,
   output logic               out_carry,
   output shift_op_t          out_op,
   output logic [TAGW-1:0]    out_tag,
   output amt_flags_t         out_flags
);

   logic [WIDTH-1:0] nxt_data;
   logic             nxt_carry;
   amt_flags_t       nxt_flags;

   always_comb begin
      nxt_data  = in_data;
      nxt_carry = in_carry;
      nxt_flags = IS_FIRST ? decode_amt(in_amt, WIDTH) : in_flags;
      // Carry tracks the last bit shifted out at each applied level.
      for (int unsigned i = LO; i < HI; i++) begin
         if (in_amt[i]) begin
            case (in_op)
               LSL: begin
                  nxt_carry = nxt_data[WIDTH - (1 << i)];
                  nxt_data  = nxt_data << (1 << i);
               end
               LSR: begin
                  nxt_carry = nxt_data[(1 << i) - 1];
                  nxt_data  = nxt_data >> (1 << i);
               end
               ASR: begin
                  nxt_carry = nxt_data[(1 << i) - 1];
                  nxt_data  = $unsigned($signed(nxt_data) >>> (1 << i));
               end
               ROR: nxt_data = (nxt_data >> (1 << i)) | (nxt_data << (WIDTH - (1 << i)));
               default: ;
            endcase
         end
      end
      if (IS_LAST) begin
         case (in_op)
            LSL: if (nxt_flags.oor) begin
               nxt_carry = nxt_flags.eq & nxt_data[0];
               nxt_data  = '0;
            end
            LSR: if (nxt_flags.oor) begin
               nxt_carry = nxt_flags.eq & nxt_data[WIDTH-1];
               nxt_data  = '0;
            end
            ASR: if (nxt_flags.oor) begin
               nxt_carry = nxt_data[WIDTH-1];
               nxt_data  = {WIDTH{nxt_data[WIDTH-1]}};
            end
            ROR: if (nxt_flags.nz) nxt_carry = nxt_data[WIDTH-1];
            RRX: begin
               nxt_carry = in_data[0];
               nxt_data  = {in_carry, in_data[WIDTH-1:1]};
            end
            default: nxt_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_amt   <= '0;
         out_carry <= 1'b0;
         out_op    <= LSL;
         out_tag   <= '0;
         out_flags <= '0;
      end else begin
         if (flush)        out_valid <= 1'b0;
         else if (advance) out_valid <= in_valid;
         if (advance) begin
            out_data  <= nxt_data;
            out_amt   <= in_amt;
            out_carry <= nxt_carry;
            out_op    <= in_op;
            out_tag   <= in_tag;
            out_flags <= nxt_flags;
         end
      end
   end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined ARM-style barrel shifter with valid/ready handshake; the whole
// pipe advances together whenever the output slot is free or being consumed.
module pipe_shifter
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAGW   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  shift_op_t          in_op,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SH_AMTW-1:0] in_amt,
   input  logic               in_carry,
   input  logic [TAGW-1:0]    in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_carry,
   output logic [TAGW-1:0]    out_tag
);

   localparam int unsigned LEVELS = $clog2(WIDTH);
   localparam int unsigned PER    = LEVELS / STAGES;

   logic [STAGES:0]    v;
   logic [STAGES:0]    c;
   logic [WIDTH-1:0]   d   [STAGES+1];
   logic [SH_AMTW-1:0] a   [STAGES+1];
   shift_op_t          op  [STAGES+1];
   logic [TAGW-1:0]    t   [STAGES+1];
   amt_flags_t         f   [STAGES+1];

   assign in_ready = !out_valid || out_ready;

   assign v[0]  = in_valid;
   assign d[0]  = in_data;
   assign a[0]  = in_amt;
   assign c[0]  = in_carry;
   assign op[0] = in_op;
   assign t[0]  = in_tag;
   assign f[0]  = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      shift_stage #(
         .WIDTH    (WIDTH),
         .TAGW     (TAGW),
         .LO       (k * PER),
         .HI       ((k == STAGES - 1) ? LEVELS : (k + 1) * PER),
         .IS_FIRST (k == 0),
         .IS_LAST  (k == STAGES - 1)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .advance   (in_ready),
         .in_valid  (v[k]),
         .in_data   (d[k]),
         .in_amt    (a[k]),
         .in_carry  (c[k]),
         .in_op     (op[k]),
         .in_tag    (t[k]),
         .in_flags  (f[k]),
         .out_valid (v[k+1]),
         .out_data  (d[k+1]),
         .out_amt   (a[k+1]),
         .out_carry (c[k+1]),
         .out_op    (op[k+1]),
         .out_tag   (t[k+1]),
         .out_flags (f[k+1])
      );
   end

   assign out_valid = v[STAGES];
   assign out_data  = d[STAGES];
   assign out_carry = c[STAGES];
   assign out_tag   = t[STAGES];

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter (WIDTH=32, STAGES=2): directed vectors plus random
// traffic against an age-tracked queue model of the pipe.
module tb_pipe_shifter;
   import shift_pkg::*;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready, in_carry;
   shift_op_t   in_op;
   logic [31:0] in_data;
   logic [7:0]  in_amt;
   logic [3:0]  in_tag;
   logic        in_ready, out_valid, out_carry;
   logic [31:0] out_data;
   logic [3:0]  out_tag;

   always #5 clk = ~clk;

   pipe_shifter #(.WIDTH(32), .STAGES(S), .TAGW(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_data(in_data), .in_amt(in_amt), .in_carry(in_carry), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_carry(out_carry), .out_tag(out_tag)
   );

   typedef struct {
      logic [31:0] d;
      logic        c;
      logic [3:0]  t;
      int          age;
   } ent_t;

   ent_t        q[$];
   logic        exp_valid = 1'b0;
   logic [31:0] exp_data  = '0;
   logic        exp_carry = 1'b0;
   logic [3:0]  exp_tag   = '0;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic [32:0] ref_shift(shift_op_t op, logic [31:0] d,
                                             int unsigned n, logic c);
      logic [31:0] r;
      int unsigned k;
      case (op)
         LSL: if (n == 0) return {c, d};
              else if (n < 32) return {d[32-n], d << n};
              else if (n == 32) return {d[0], 32'h0};
              else return 33'h0;
         LSR: if (n == 0) return {c, d};
              else if (n < 32) return {d[n-1], d >> n};
              else if (n == 32) return {d[31], 32'h0};
              else return 33'h0;
         ASR: if (n == 0) return {c, d};
              else if (n < 32) return {d[n-1], 32'($signed(d) >>> n)};
              else return {d[31], {32{d[31]}}};
         ROR: begin
            if (n == 0) return {c, d};
            k = n % 32;
            r = (d >> k) | (d << (32 - k));
            return {r[31], r};
         end
         RRX: return {d[0], c, d[31:1]};
         default: return {c, 32'h0};
      endcase
   endfunction

   // Advance the model across one rising edge using the inputs now driven.
   task automatic step();
      logic mready, acc;
      logic [32:0] r;
      ent_t e;
      mready = !exp_valid || out_ready;
      acc    = in_valid && mready;
      r      = ref_shift(in_op, in_data, in_amt, in_carry);
      e.d = r[31:0]; e.c = r[32]; e.t = in_tag; e.age = 1;
      @(posedge clk);
      if (reset) begin
         q.delete();
         exp_valid = 1'b0; exp_data = '0; exp_carry = 1'b0; exp_tag = '0;
      end else if (flush) begin
         q.delete();
         exp_valid = 1'b0;
      end else if (mready) begin
         if (q.size() > 0 && q[0].age == S) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (acc) q.push_back(e);
         if (q.size() > 0 && q[0].age == S) begin
            exp_valid = 1'b1; exp_data = q[0].d; exp_carry = q[0].c; exp_tag = q[0].t;
         end else begin
            exp_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = LSL; in_data = '0; in_amt = '0; in_carry = 1'b0; in_tag = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
          out_carry !== 1'b0 || out_tag !== 4'h0) begin
         n_err++;
         $display("FAIL reset_state: v=%b r=%b d=%h c=%b t=%h required 0 1 00000000 0 0",
                  out_valid, in_ready, out_data, out_carry, out_tag);
      end
      reset = 1'b0;
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_directed();
      shift_op_t   vop [14] = '{LSL, ASR, LSR, RRX, ROR, LSL, shift_op_t'(3'd6),
                                LSL, ROR, LSR, ASR, LSL, ASR, ROR};
      logic [31:0] vd  [14] = '{32'h80000001, 32'h80000000, 32'h80000000, 32'h00000003,
                                32'h000000F0, 32'h00001234, 32'h000000FF, 32'h00000001,
                                32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000003,
                                32'h80000010, 32'h12345678};
      logic [7:0]  va  [14] = '{8'd1, 8'd40, 8'd32, 8'd7, 8'd36, 8'd0, 8'd3, 8'd32,
                                8'd32, 8'd33, 8'd32, 8'd31, 8'd5, 8'd8};
      logic        vc  [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] ed  [14] = '{32'h00000002, 32'hFFFFFFFF, 32'h00000000, 32'h80000001,
                                32'h0000000F, 32'h00001234, 32'h00000000, 32'h00000000,
                                32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000,
                                32'hFC000000, 32'h78123456};
      logic        ec  [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      idle_inputs();
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1; in_op = vop[i]; in_data = vd[i]; in_amt = va[i];
         in_carry = vc[i]; in_tag = 4'(i);
         step();
         in_valid = 1'b0;
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== ed[i] || out_carry !== ec[i] ||
             out_tag !== 4'(i)) begin
            n_err++;
            $display("FAIL directed_%0d: v=%b d=%h c=%b t=%h required 1 %h %b %h",
                     i, out_valid, out_data, out_carry, out_tag, ed[i], ec[i], 4'(i));
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [7:0] pick [7];
      idle_inputs();
      for (int i = 0; i < 500; i++) begin
         pick = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'($urandom_range(0, 40)), 8'($urandom)};
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 32) == 0;
         in_op     = shift_op_t'(3'($urandom_range(0, 7)));
         in_data   = $urandom;
         in_amt    = pick[$urandom_range(0, 6)];
         in_carry  = 1'($urandom);
         in_tag    = 4'($urandom);
         step();
         n_cmp++;
         if (out_valid !== exp_valid || in_ready !== (!exp_valid || out_ready)) begin
            n_err++;
            $display("FAIL rand_hs @%0d: v=%b rdy=%b required v=%b rdy=%b",
                     i, out_valid, in_ready, exp_valid, !exp_valid || out_ready);
         end
         if (exp_valid) begin
            n_cmp++;
            if (out_data !== exp_data || out_carry !== exp_carry || out_tag !== exp_tag) begin
               n_err++;
               $display("FAIL rand_data @%0d: d=%h c=%b t=%h required %h %b %h",
                        i, out_data, out_carry, out_tag, exp_data, exp_carry, exp_tag);
            end
         end
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) step();
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int got  = 0;
      logic acc;
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         out_ready = !(i >= 3 && i <= 5);
         in_valid  = sent < 8;
         in_op     = shift_op_t'(3'($urandom_range(0, 4)));
         in_data   = $urandom;
         in_amt    = 8'($urandom_range(0, 40));
         in_carry  = 1'($urandom);
         in_tag    = 4'(sent);
         if (out_valid && out_ready) begin
            n_cmp++;
            if (out_tag !== 4'(got)) begin
               n_err++;
               $display("FAIL b2b_order: tag=%h required %h", out_tag, 4'(got));
            end
            got++;
         end
         acc = in_valid && (!exp_valid || out_ready);
         step();
         if (acc) sent++;
         n_cmp++;
         if (out_valid !== exp_valid || in_ready !== (!exp_valid || out_ready)) begin
            n_err++;
            $display("FAIL b2b_hs @%0d: v=%b rdy=%b required v=%b rdy=%b",
                     i, out_valid, in_ready, exp_valid, !exp_valid || out_ready);
         end
         if (exp_valid) begin
            n_cmp++;
            if (out_data !== exp_data || out_carry !== exp_carry || out_tag !== exp_tag) begin
               n_err++;
               $display("FAIL b2b_data @%0d: d=%h c=%b t=%h required %h %b %h",
                        i, out_data, out_carry, out_tag, exp_data, exp_carry, exp_tag);
            end
         end
      end
      n_cmp++;
      if (got !== 8) begin
         n_err++;
         $display("FAIL b2b_count: presented=%0d required 8", got);
      end
   endtask

   task automatic test_flush();
      idle_inputs();
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = LSL; in_data = 32'h11; in_amt = 8'd1; in_tag = 4'h1;
      step();
      in_tag = 4'h2; in_data = 32'h22;
      step();
      in_tag = 4'h3; in_data = 32'h33; flush = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_valid !== exp_valid) begin
         n_err++;
         $display("FAIL flush_drop: out_valid=%b required 0", out_valid);
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_empty: v=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      in_valid = 1'b1; in_tag = 4'h4; in_data = 32'h44;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_lat1: out_valid=%b required 0", out_valid);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_tag !== 4'h4 || out_data !== 32'h88 ||
          out_data !== exp_data) begin
         n_err++;
         $display("FAIL flush_next: v=%b t=%h d=%h required 1 4 00000088",
                  out_valid, out_tag, out_data);
      end
      step();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_op = ROR; in_data = $urandom; in_amt = 8'(i + 1);
         in_tag = 4'(i + 9);
         step();
      end
      reset = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
          out_carry !== 1'b0 || out_tag !== 4'h0) begin
         n_err++;
         $display("FAIL reset_mid: v=%b r=%b d=%h c=%b t=%h required 0 1 00000000 0 0",
                  out_valid, in_ready, out_data, out_carry, out_tag);
      end
      reset = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stale @%0d: out_valid=%b required 0", i, out_valid);
         end
      end
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; a power of two, 8..64.
REQ-002 Parameter STAGES, default 2: pipeline depth in cycles; range 1..log2(WIDTH).
REQ-003 Parameter TAGW, default 4: width of the pass-through tag (destination register number).
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous kill of all in-flight operations.
REQ-007 in_valid  in  1  input operation present.
REQ-008 in_ready  out  1  block accepts an input this cycle.
REQ-009 in_op  in  3  shift_op_t: LSL, LSR, ASR, ROR, RRX.
REQ-010 in_data  in  WIDTH  operand to shift (Rm value).
REQ-011 in_amt  in  8  unsigned shift amount (immediate shamt or Rs[7:0]).
REQ-012 in_carry  in  1  current C flag.
REQ-013 in_tag  in  TAGW  carried unchanged to out_tag.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  consumer accepts the result this cycle.
REQ-016 out_data  out  WIDTH  shifted result.
REQ-017 out_carry  out  1  shifter carry-out.
REQ-018 out_tag  out  TAGW  tag of the presented result.

Function
REQ-019 Accept occurs when in_valid and in_ready are both 1; present occurs when out_valid and out_ready are both 1.
REQ-020 in_ready SHALL equal (!out_valid || out_ready); the whole pipe advances together on that condition.
REQ-021 Latency SHALL be exactly STAGES cycles from accept to out_valid when not stalled; throughput one op per cycle.
REQ-022 While stalled (out_valid && !out_ready), every stage register, including out_*, SHALL hold its value.
REQ-023 Stage k SHALL apply amount bits for its share of log2(WIDTH) levels, LSB levels first; the split is balanced, with the last stage taking the remainder.
REQ-024 Amount 0, any op except RRX: out_data = in_data; out_carry = in_carry.
REQ-025 LSL n, 1<=n<WIDTH: carry = data[WIDTH-n]; n==WIDTH: result 0, carry = data[0]; n>WIDTH: result 0, carry 0.
REQ-026 LSR n, 1<=n<WIDTH: carry = data[n-1]; n==WIDTH: result 0, carry = data[WIDTH-1]; n>WIDTH: result 0, carry 0.
REQ-027 ASR n, 1<=n<WIDTH: carry = data[n-1]; n>=WIDTH: every result bit = data[WIDTH-1], carry = data[WIDTH-1].
REQ-028 ROR: rotate by n mod WIDTH; carry = result[WIDTH-1]; a nonzero n that is a multiple of WIDTH gives result = data.
REQ-029 RRX: ignores in_amt; result = {in_carry, data[WIDTH-1:1]}; carry = data[0].
REQ-030 Undefined in_op encodings SHALL produce result 0 and carry = in_carry, with no error raised.
REQ-031 flush SHALL clear every stage valid bit at the next edge; an input offered in the same cycle is discarded, and in_ready is unaffected by flush.
REQ-032 If flush and stall coincide, flush wins: the held output is dropped.
REQ-033 Data and tag registers need not be cleared by flush or reset; only valid bits and out_* are reset.

Reset
REQ-034 reset SHALL dominate flush and the handshake, and SHALL take effect at the first rising edge at which it is high.
REQ-035 After reset: all valid bits 0, out_valid 0, out_data 0, out_carry 0, out_tag 0, in_ready 1.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight operations; nothing is presented afterwards.

Structure
REQ-037 Package shift_pkg SHALL hold shift_op_t (LSL=0, LSR=1, ASR=2, ROR=3, RRX=4) and the constant SH_AMTW=8.
REQ-038 Sub-module shift_stage SHALL be instantiated STAGES times; it implements a combinational run of shift levels plus a registered valid/data/amt/carry/op/tag slice.
REQ-039 Out-of-range amounts (n>=WIDTH) SHALL be pre-decoded in stage 0 into flags carried down the pipe.

Verification (WIDTH=32, STAGES=2)
REQ-040 LSL, data 0x80000001, amt 1, carry 0 -> two cycles later out_data 0x00000002, out_carry 1.
REQ-041 ASR, data 0x80000000, amt 40 -> out_data 0xFFFFFFFF, out_carry 1; LSR with the same data and amt 32 -> 0x00000000, carry 1.
REQ-042 RRX, data 0x00000003, carry 1 -> out_data 0x80000001, out_carry 1; ROR, data 0x000000F0, amt 36 -> 0x0000000F, carry 0.
REQ-043 Back-to-back stream of 8 ops with out_ready low for cycles 3-5 -> no loss or duplication, order and tags preserved, in_ready low exactly while stalled.
REQ-044 flush pulsed while 2 ops are in flight and in_valid is high -> none of those 3 ops appear; the next accepted op emerges after 2 cycles.
REQ-045 reset asserted for 1 cycle mid-stream -> all outputs 0 and in_ready 1 on the following cycle; no stale out_valid.
